// File: rtl/divisor_serial_if.sv
// Handshake and operand bundle between the control unit and the serial divider.
interface divisor_serial_if #(
    parameter int BITS = 64
);
    logic            start;
    logic            assinado;
    logic [BITS-1:0] dividendo;
    logic [BITS-1:0] divisor;
    logic [BITS-1:0] quociente;
    logic [BITS-1:0] resto;
    logic            ocupado;
    logic            pronto;

    modport master (
        output start, assinado, dividendo, divisor,
        input  quociente, resto, ocupado, pronto
    );

    modport slave (
        input  start, assinado, dividendo, divisor,
        output quociente, resto, ocupado, pronto
    );
endinterface

// File: rtl/divisor_serial.sv
// Iterative restoring divider for RV64M DIV/DIVU/REM/REMU: one quotient bit per clock,
// with RISC-V divide-by-zero and signed-overflow results produced in a single cycle.
module divisor_serial #(
    parameter int BITS = 64
) (
    input  logic            clk,
    input  logic            reset,
    divisor_serial_if.slave bus
);
    localparam int CW = $clog2(BITS + 1);

    typedef enum logic [1:0] {OCIOSO, DIVIDINDO, AJUSTE, FIM} estado_t;

    estado_t         estado;
    logic [BITS-1:0] dvd_q;      // dividend magnitude, refilled from the LSB with quotient bits
    logic [BITS-1:0] dsr;
    logic [BITS-1:0] rem;
    logic [CW-1:0]   cnt;
    logic            neg_q;
    logic            neg_r;
    logic [BITS-1:0] quociente_r;
    logic [BITS-1:0] resto_r;
    logic            ocupado_r;
    logic            pronto_r;

    logic            sgn_a;
    logic            sgn_b;
    logic            div_zero;
    logic            ovf;
    logic [BITS-1:0] mag_a;
    logic [BITS-1:0] mag_b;
    logic [BITS-1:0] min_neg;
    logic [BITS:0]   rem_sh;
    logic [BITS:0]   diff;

    always_comb begin
        sgn_a            = bus.assinado & bus.dividendo[BITS-1];
        sgn_b            = bus.assinado & bus.divisor[BITS-1];
        mag_a            = sgn_a ? -bus.dividendo : bus.dividendo;
        mag_b            = sgn_b ? -bus.divisor : bus.divisor;
        min_neg          = '0;
        min_neg[BITS-1]  = 1'b1;
        div_zero         = (bus.divisor == '0);
        ovf              = bus.assinado && (bus.dividendo == min_neg) && (bus.divisor == '1);
        // rem < dsr always holds, so a set bit BITS in diff means the trial went negative
        rem_sh           = {rem, dvd_q[BITS-1]};
        diff             = rem_sh - {1'b0, dsr};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado      <= OCIOSO;
            dvd_q       <= '0;
            dsr         <= '0;
            rem         <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quociente_r <= '0;
            resto_r     <= '0;
            ocupado_r   <= 1'b0;
            pronto_r    <= 1'b0;
        end else begin
            pronto_r <= 1'b0;
            case (estado)
                OCIOSO, FIM: begin
                    if (bus.start) begin
                        if (div_zero) begin
                            quociente_r <= '1;
                            resto_r     <= bus.dividendo;
                            pronto_r    <= 1'b1;
                            estado      <= FIM;
                        end else if (ovf) begin
                            quociente_r <= bus.dividendo;
                            resto_r     <= '0;
                            pronto_r    <= 1'b1;
                            estado      <= FIM;
                        end else begin
                            dvd_q     <= mag_a;
                            dsr       <= mag_b;
                            rem       <= '0;
                            cnt       <= CW'(BITS);
                            neg_q     <= bus.assinado & (bus.dividendo[BITS-1] ^ bus.divisor[BITS-1]);
                            neg_r     <= sgn_a;
                            ocupado_r <= 1'b1;
                            estado    <= DIVIDINDO;
                        end
                    end else begin
                        estado <= OCIOSO;
                    end
                end
                DIVIDINDO: begin
                    if (!diff[BITS]) begin
                        rem <= diff[BITS-1:0];
                    end else begin
                        rem <= rem_sh[BITS-1:0];
                    end
                    dvd_q <= {dvd_q[BITS-2:0], ~diff[BITS]};
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        estado <= AJUSTE;
                    end
                end
                AJUSTE: begin
                    quociente_r <= neg_q ? -dvd_q : dvd_q;
                    resto_r     <= neg_r ? -rem : rem;
                    ocupado_r   <= 1'b0;
                    pronto_r    <= 1'b1;
                    estado      <= FIM;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

    assign bus.quociente = quociente_r;
    assign bus.resto     = resto_r;
    assign bus.ocupado   = ocupado_r;
    assign bus.pronto    = pronto_r;
endmodule

// File: tb/tb_divisor_serial.sv
// Scoreboard bench for divisor_serial: driver queues expected results from an arithmetic
// reference model, a monitor pops and compares on every pronto pulse.
module tb_divisor_serial;
    localparam int BITS = 64;
    localparam logic [63:0] MIN_NEG  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
        int          ocu;
        int          issue;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   ocu_cnt = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    divisor_serial_if #(.BITS(BITS)) bus ();
    divisor_serial #(.BITS(BITS)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // RISC-V division semantics with plain arithmetic
    function automatic exp_t model(input logic s, input logic [63:0] a, input logic [63:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        e.issue = 0;
        if (b == 64'd0) begin
            e.q = ALL_ONES; e.r = a; e.lat = 1; e.ocu = 0;
        end else if (s && a == MIN_NEG && b == ALL_ONES) begin
            e.q = MIN_NEG; e.r = 64'd0; e.lat = 1; e.ocu = 0;
        end else begin
            e.lat = BITS + 2;
            e.ocu = BITS + 1;
            if (s) begin
                sa  = $signed(a);
                sb  = $signed(b);
                e.q = 64'(sa / sb);
                e.r = 64'(sa % sb);
            end else begin
                e.q = a / b;
                e.r = a % b;
            end
        end
        return e;
    endfunction

    // Called at a negedge; returns at the following negedge with start dropped.
    task automatic issue(input logic s, input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        e              = model(s, a, b);
        e.issue        = cyc;
        bus.assinado   = s;
        bus.dividendo  = a;
        bus.divisor    = b;
        bus.start      = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start      = 1'b0;
        bus.assinado   = 1'($urandom);
        bus.dividendo  = {$urandom, $urandom};
        bus.divisor    = {$urandom, $urandom};
    endtask

    task automatic pulse_ignored(input logic s, input logic [63:0] a, input logic [63:0] b);
        bus.assinado  = s;
        bus.dividendo = a;
        bus.divisor   = b;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout_idle actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_pronto();
        for (int i = 0; i < 400 && !bus.pronto; i++) @(negedge clk);
        if (!bus.pronto) begin
            checks++;
            failures++;
            $display("FAIL timeout_pronto actual=0 required=1");
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            ocu_cnt = 0;
        end else begin
            if (bus.ocupado) ocu_cnt++;
            if (bus.pronto) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pronto actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("quociente", bus.quociente, e.q);
                    chk("resto", bus.resto, e.r);
                    chk("latencia", 64'(cyc - e.issue), 64'(e.lat));
                    chk("ocupado_ciclos", 64'(ocu_cnt), 64'(e.ocu));
                end
                ocu_cnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int pr;
        logic s;
        logic [63:0] a;
        logic [63:0] b;
        bus.start = 1'b0; bus.assinado = 1'b0; bus.dividendo = '0; bus.divisor = '0;
        repeat (3) @(negedge clk);
        chk("reset_quociente", bus.quociente, 64'd0);
        chk("reset_resto", bus.resto, 64'd0);
        chk("reset_ocupado", 64'(bus.ocupado), 64'd0);
        chk("reset_pronto", 64'(bus.pronto), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(1'b0, 64'd100, 64'd7);                               wait_idle();
        issue(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);               wait_idle();
        issue(1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE);               wait_idle();
        issue(1'b0, 64'd5, 64'd0);                                 wait_idle();
        issue(1'b1, 64'd5, 64'd0);                                 wait_idle();
        issue(1'b1, MIN_NEG, ALL_ONES);                            wait_idle();
        issue(1'b0, MIN_NEG, ALL_ONES);                            wait_idle();

        // start while busy is ignored; start in the FIM cycle chains a new operation
        issue(1'b0, 64'd100, 64'd7);
        repeat (8) @(negedge clk);
        pulse_ignored(1'b0, 64'd9, 64'd3);
        wait_pronto();
        issue(1'b0, 64'd9, 64'd3);
        wait_idle();

        // reset mid-operation abandons it without a pronto
        issue(1'b0, ALL_ONES, 64'd1);
        repeat (29) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_quociente", bus.quociente, 64'd0);
        chk("midreset_resto", bus.resto, 64'd0);
        chk("midreset_ocupado", 64'(bus.ocupado), 64'd0);
        chk("midreset_pronto", 64'(bus.pronto), 64'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        pr = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (bus.pronto) pr++;
        end
        chk("no_pronto_after_reset", 64'(pr), 64'd0);
        issue(1'b0, ALL_ONES, 64'd1);
        wait_idle();

        for (int n = 0; n < 40; n++) begin
            s = 1'($urandom);
            a = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0:       b = 64'd0;
                1:       begin s = 1'b1; a = MIN_NEG; b = ALL_ONES; end
                2:       b = 64'($urandom_range(1, 15));
                default: b = {$urandom, $urandom} >> $urandom_range(0, 63);
            endcase
            if (exp_q.size() != 0) begin
                if ($urandom_range(0, 1) == 1) wait_pronto();
                else wait_idle();
            end
            issue(s, a, b);
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/divisor_serial.md
Name: divisor_serial

Overview:
- Multi-cycle iterative integer divider for the RV64M DIV/DIVU/REM/REMU instructions.
- Sits beside the ULA in the execute stage and reuses the same subtract-and-compare datapath style.
- Produces one quotient bit per clock using restoring division, with a start/ocupado/pronto handshake toward the control unit.
- Applies RISC-V rules for division by zero and signed overflow.

Parameters:
BITS, 64, operand/result width; must be >= 2.

Ports:
clk  input  1  clock, all registers on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request a division; sampled only in OCIOSO or FIM
assinado  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU); latched with start
dividendo  input  BITS  dividend; latched with start
divisor  input  BITS  divisor; latched with start
quociente  output  BITS  registered quotient
resto  output  BITS  registered remainder
ocupado  output  1  high while an operation is in progress (states DIVIDINDO, AJUSTE)
pronto  output  1  one-cycle pulse; quociente/resto are valid from this cycle on

Behaviour:
- Reset (asynchronous): state=OCIOSO; quociente=0, resto=0, ocupado=0, pronto=0; iteration counter and operand registers cleared. Reset mid-operation abandons the operation. No pronto is produced for it.
- States: OCIOSO, DIVIDINDO, AJUSTE, FIM.
- OCIOSO/FIM with start=1, normal case:
  - Latch assinado, dividendo and divisor.
  - Magnitudes: when assinado=1, take the absolute value of each negative operand. Otherwise use the raw operands.
  - Record neg_q = assinado & (sign(dividendo) XOR sign(divisor)) and neg_r = assinado & sign(dividendo).
  - Partial remainder = 0, counter = BITS, next state DIVIDINDO.
- Special cases, detected at the start edge; go directly to FIM and update the outputs on that same edge:
  - divisor == 0: quociente = all ones, resto = dividendo (both signed and unsigned).
  - assinado=1, dividendo = 1 followed by BITS-1 zeros, divisor = all ones: quociente = dividendo, resto = 0.
- DIVIDINDO, each edge:
  - Shift the dividend MSB into the partial remainder and form a BITS+1-bit trial difference = remainder - divisor magnitude.
  - If the difference is non-negative: remainder = difference, quotient bit = 1. Otherwise: remainder unchanged, quotient bit = 0.
  - Counter decrements. After BITS edges the next state is AJUSTE.
- AJUSTE, one edge: quociente = neg_q ? two's-complement negate of q : q; resto = neg_r ? negate of r : r. Next state FIM.
- FIM: pronto=1 for exactly one cycle. Next state OCIOSO, or a new operation if start=1 (back-to-back is allowed).
- Latency:
  - Normal: start sampled at edge k -> pronto high in the cycle after edge k+BITS+1, i.e. BITS+2 cycles (66 for BITS=64).
  - Special case: pronto high in the cycle after edge k (1 cycle).
- ocupado = 1 exactly in DIVIDINDO and AJUSTE. start during ocupado is ignored, and in-flight operands are unaffected by input changes.
- quociente/resto change only on the edge entering FIM, and hold their value until the next operation's FIM edge.
- All arithmetic is modulo 2^BITS except the internal BITS+1-bit trial subtraction. No overflow flag output.

Test Plan:
1. assinado=0, dividendo=100, divisor=7, start for 1 cycle -> ocupado high 65 cycles; pronto pulses 66 cycles after start; quociente=14, resto=2.
2. assinado=1, dividendo=-7 (0xFFFF_FFFF_FFFF_FFF9), divisor=2 -> quociente=0xFFFF_FFFF_FFFF_FFFD (-3), resto=0xFFFF_FFFF_FFFF_FFFF (-1). Repeat with 7/-2 -> quociente=-3, resto=1.
3. Divide by zero, dividendo=5, divisor=0, both assinado values -> pronto 1 cycle after start, ocupado never high; quociente=0xFFFF_FFFF_FFFF_FFFF, resto=5.
4. Signed overflow, assinado=1, dividendo=0x8000_0000_0000_0000, divisor=0xFFFF_FFFF_FFFF_FFFF -> quociente=0x8000_0000_0000_0000, resto=0, 1-cycle latency. Same operands with assinado=0 -> quociente=0, resto=0x8000_0000_0000_0000 after 66 cycles.
5. Start 100/7; pulse start with 9/3 at cycle 10 while ocupado -> ignored, result 14/2. Issue start in the FIM cycle with 9/3 -> second pronto 66 cycles later with quociente=3, resto=0.
6. Start 0xFFFF_FFFF_FFFF_FFFF/1 unsigned; assert reset at cycle 30 -> all outputs 0 immediately, state OCIOSO, no pronto. Release reset and start 0xFFFF_FFFF_FFFF_FFFF/1 -> quociente=0xFFFF_FFFF_FFFF_FFFF, resto=0.
